ram64_reorder_ctrl: RTL and testbench

Address sequencer and handshake controller for the 64-entry, 4-port synchronous RAM used as the radix-4 reorder buffer between FFT pipeline stages. Input arrives as 16 beats of 4 samples in natural order; each beat is written into the RAM while the previous frame's samples are read out in stride-16 order. One RAM gives gapless streaming because the controller rotates the base-4 address digits every frame (in-place read-before-write). A FLUSH request drains the final frame without new input.

---
 rtl/ram64_reorder_ctrl_pkg.sv | 38 +++
 rtl/ram64_reorder_ctrl_if.sv | 33 +++
 rtl/ram64_addr_rot.sv | 32 +++
 rtl/ram64_reorder_ctrl.sv | 130 +++++++++++++
 tb/tb_ram64_reorder_ctrl.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram64_reorder_ctrl_pkg.sv
// Shared constants, state encoding and address helpers for the 64-entry reorder buffer controller.
package ram64_reorder_ctrl_pkg;

  localparam int unsigned FrameBeats = 16;
  localparam int unsigned Lanes      = 4;
  localparam int unsigned AddrW      = 6;
  localparam int unsigned CntW       = 4;
  localparam int unsigned ModeW      = 2;

  // State encodings, kept as named constants so other blocks can decode a raw state word.
  localparam logic [1:0] StateIdleEnc   = 2'd0;
  localparam logic [1:0] StateFillEnc   = 2'd1;
  localparam logic [1:0] StateStreamEnc = 2'd2;
  localparam logic [1:0] StateDrainEnc  = 2'd3;

  typedef enum logic [1:0] {
    StIdle   = StateIdleEnc,
    StFill   = StateFillEnc,
    StStream = StateStreamEnc,
    StDrain  = StateDrainEnc
  } state_e;

  // Address mode: how many times the base-4 digits of the linear position are rotated.
  localparam logic [ModeW-1:0] ModeLin  = 2'd0;
  localparam logic [ModeW-1:0] ModeRot1 = 2'd1;
  localparam logic [ModeW-1:0] ModeRot2 = 2'd2;

  // Rotate the three base-4 digits: the lowest digit moves to the top.
  function automatic logic [AddrW-1:0] rot_addr(input logic [AddrW-1:0] x);
    return {x[1:0], x[AddrW-1:2]};
  endfunction

  // Next address mode at a frame boundary; three rotations are the identity, so wrap 2 -> 0.
  function automatic logic [ModeW-1:0] next_mode(input logic [ModeW-1:0] m);
    return (m == ModeRot2) ? ModeLin : m + 2'd1;
  endfunction

endpackage

// File: rtl/ram64_reorder_ctrl_if.sv
// Handshake and RAM-control bundle between an FFT stage and its reorder-buffer controller.
interface ram64_reorder_ctrl_if;
  import ram64_reorder_ctrl_pkg::*;

  logic             ed;
  logic             in_vld;
  logic             in_rdy;
  logic             flush;
  logic             ram_ed;
  logic             ram_we;
  logic [AddrW-1:0] ram_addr_0;
  logic [AddrW-1:0] ram_addr_1;
  logic [AddrW-1:0] ram_addr_2;
  logic [AddrW-1:0] ram_addr_3;
  logic             out_vld;
  logic             out_first;
  logic             busy;

  // Stage side: supplies enable, beats and flush requests; observes the controller.
  modport master (
    output ed, in_vld, flush,
    input  in_rdy, ram_ed, ram_we, ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3,
    input  out_vld, out_first, busy
  );

  // Controller side.
  modport slave (
    input  ed, in_vld, flush,
    output in_rdy, ram_ed, ram_we, ram_addr_0, ram_addr_1, ram_addr_2, ram_addr_3,
    output out_vld, out_first, busy
  );

endinterface

// File: rtl/ram64_addr_rot.sv
// Combinational lane-address generator: linear position {cnt, lane} rotated by the current mode.
module ram64_addr_rot
  import ram64_reorder_ctrl_pkg::*;
(
  input  logic [CntW-1:0]               cnt_i,
  input  logic [ModeW-1:0]              mode_i,
  output logic [Lanes-1:0][AddrW-1:0]   addr_o
);

  logic [Lanes-1:0][AddrW-1:0] lin;

  // Linear sample position of each lane within the frame.
  always_comb begin
    lin = '0;
    for (int l = 0; l < Lanes; l++) begin
      lin[l] = {cnt_i, 2'(l)};
    end
  end

  // Apply zero, one or two digit rotations; lanes differ in the low digit so stay distinct.
  always_comb begin
    addr_o = '0;
    for (int l = 0; l < Lanes; l++) begin
      case (mode_i)
        ModeRot1: addr_o[l] = rot_addr(lin[l]);
        ModeRot2: addr_o[l] = rot_addr(rot_addr(lin[l]));
        default:  addr_o[l] = lin[l];
      endcase
    end
  end

endmodule

// File: rtl/ram64_reorder_ctrl.sv
// Address sequencer and handshake controller for the 64-entry radix-4 reorder RAM.
// Each step reads the previous frame's sample and writes the new one at the same address;
// rotating the address digits every frame keeps one RAM streaming without gaps.
module ram64_reorder_ctrl
  import ram64_reorder_ctrl_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  ram64_reorder_ctrl_if.slave  bus_io
);

  state_e                     state_q, state_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic [ModeW-1:0]           mode_q, mode_d;
  logic                       flush_pend_q, flush_pend_d;
  logic                       out_vld_q, out_vld_d;
  logic                       out_first_q, out_first_d;

  logic                       in_rdy;
  logic                       acc;
  logic                       step;
  logic                       adv;
  logic                       last_beat;
  logic                       boundary;
  logic                       drain_exit;
  logic                       flush_hold;
  logic [Lanes-1:0][AddrW-1:0] addr;

  ram64_addr_rot u_addr_rot (
    .cnt_i  (cnt_q),
    .mode_i (mode_q),
    .addr_o (addr)
  );

  // Handshake and step qualification; in_rdy depends on registers only.
  always_comb begin
    flush_hold = flush_pend_q && (cnt_q == '0) && (state_q == StStream);
    in_rdy     = (state_q != StDrain) && !flush_hold;
    acc        = bus_io.in_vld && in_rdy;
    step       = (state_q == StDrain) ? 1'b1 : acc;
    adv        = bus_io.ed && step;
    last_beat  = (cnt_q == CntW'(FrameBeats - 1));
    boundary   = adv && last_beat;
    drain_exit = boundary && (state_q == StDrain);
  end

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; nothing moves while the global enable is low.
  always_comb begin
    state_d = state_q;
    if (bus_io.ed) begin
      unique case (state_q)
        StIdle:   if (acc) state_d = StFill;
        StFill:   if (boundary) state_d = StStream;
        StStream: if (flush_hold) state_d = StDrain;
        StDrain:  if (boundary) state_d = StIdle;
        default:  state_d = StIdle;
      endcase
    end
  end

  // Beat counter, address mode, pending flush and the registered output qualifiers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q        <= '0;
      mode_q       <= ModeLin;
      flush_pend_q <= 1'b0;
      out_vld_q    <= 1'b0;
      out_first_q  <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      mode_q       <= mode_d;
      flush_pend_q <= flush_pend_d;
      out_vld_q    <= out_vld_d;
      out_first_q  <= out_first_d;
    end
  end

  // Datapath next-state. A flush during a partial frame only latches here; the STREAM
  // state acts on it once the counter is back at a frame boundary.
  always_comb begin
    cnt_d        = cnt_q;
    mode_d       = mode_q;
    flush_pend_d = flush_pend_q;
    out_vld_d    = out_vld_q;
    out_first_d  = out_first_q;
    if (bus_io.ed) begin
      if (adv) begin
        cnt_d = cnt_q + 1'b1;
      end
      if (boundary) begin
        mode_d = next_mode(mode_q);
      end
      if (bus_io.flush && (state_q == StFill || state_q == StStream)) begin
        flush_pend_d = 1'b1;
      end
      if (drain_exit) begin
        cnt_d        = '0;
        mode_d       = ModeLin;
        flush_pend_d = 1'b0;
      end
      // Read data appears one cycle after the step, so the valid flag is registered.
      out_vld_d   = step && (state_q == StStream || state_q == StDrain);
      out_first_d = out_vld_d && (cnt_q == '0);
    end
  end

  // Output decode.
  always_comb begin
    bus_io.in_rdy     = in_rdy;
    bus_io.ram_ed     = adv;
    bus_io.ram_we     = (state_q != StDrain);
    bus_io.busy       = (state_q != StIdle);
    bus_io.ram_addr_0 = addr[0];
    bus_io.ram_addr_1 = addr[1];
    bus_io.ram_addr_2 = addr[2];
    bus_io.ram_addr_3 = addr[3];
    bus_io.out_vld    = out_vld_q;
    bus_io.out_first  = out_first_q;
  end

endmodule

// File: tb/tb_ram64_reorder_ctrl.sv
// Self-checking bench: controller plus a behavioural 4-port read-before-write RAM,
// with a scoreboard of stride-ordered output beats.
module tb_ram64_reorder_ctrl;
  import ram64_reorder_ctrl_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ram64_reorder_ctrl_if bus ();

  ram64_reorder_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  // Behavioural RAM: registered read of the old contents, write of the new beat.
  logic [15:0] mem  [64];
  logic [15:0] di   [4];
  logic [15:0] dout [4];
  logic [5:0]  ra   [4];
  logic [23:0] addrs;

  assign ra[0] = bus.ram_addr_0;
  assign ra[1] = bus.ram_addr_1;
  assign ra[2] = bus.ram_addr_2;
  assign ra[3] = bus.ram_addr_3;
  assign addrs = {bus.ram_addr_3, bus.ram_addr_2, bus.ram_addr_1, bus.ram_addr_0};

  always @(posedge clk) begin
    if (bus.ram_ed) begin
      for (int l = 0; l < 4; l++) begin
        dout[l] <= mem[ra[l]];
        if (bus.ram_we) mem[ra[l]] <= di[l];
      end
    end
  end

  typedef struct packed {
    logic        first;
    logic [63:0] d;
  } exp_t;

  typedef struct packed {
    logic        ed;
    logic        vld;
    logic [16:0] exp;  // {in_rdy, busy, ram_we, ram_ed, out_vld, addr0, addr1}
  } vec_t;

  exp_t        sb[$];
  vec_t        vt [6];
  logic [23:0] mode_tab [3];

  int checks = 0;
  int errors = 0;
  int acc_beat = 0;
  int frame_no = 0;
  int gframe = 0;
  bit last_acc;
  bit ed_prev;

  task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input bit e, input bit v, input bit rdy, input bit bsy,
                               input bit we, input bit red, input bit ov,
                               input logic [5:0] a0, input logic [5:0] a1);
    vec_t r;
    r.ed  = e;
    r.vld = v;
    r.exp = {rdy, bsy, we, red, ov, a0, a1};
    return r;
  endfunction

  // Apply inputs just after an edge; data carries the global frame and sample index.
  task automatic drive(input bit v, input bit fl, input bit e);
    bus.in_vld = v;
    bus.flush  = fl;
    bus.ed     = e;
    for (int l = 0; l < 4; l++) di[l] = 16'(gframe * 64 + acc_beat * 4 + l);
    #1;
  endtask

  // Advance one clock; on a completed frame queue its 16 stride-ordered output beats.
  task automatic tick();
    exp_t e;
    int   b;
    last_acc = bus.ed && bus.in_vld && bus.in_rdy;
    if (last_acc && acc_beat == 1) chk("mode_addr", 80'(addrs), 80'(mode_tab[frame_no % 3]));
    @(posedge clk);
    #1;
    if (last_acc) begin
      if (acc_beat == 15) begin
        for (int c = 0; c < 16; c++) begin
          b       = gframe * 64 + c;
          e.first = (c == 0);
          e.d     = {16'(b + 48), 16'(b + 32), 16'(b + 16), 16'(b)};
          sb.push_back(e);
        end
        gframe++;
        frame_no++;
        acc_beat = 0;
      end else begin
        acc_beat++;
      end
    end
  endtask

  task automatic feed(input int n, input bit bubble);
    int got = 0;
    bit v = 1'b1;
    for (int g = 0; g < 4 * n + 8 && got < n; g++) begin
      drive(v, 1'b0, 1'b1);
      tick();
      if (last_acc) got++;
      if (bubble) v = !v;
    end
    chk("feed_count", 80'(got), 80'(n));
  endtask

  initial begin
    exp_t        e;
    logic [25:0] saved;
    int          dn;
    bit          seen;

    mode_tab[0] = {6'd7, 6'd6, 6'd5, 6'd4};
    mode_tab[1] = {6'd49, 6'd33, 6'd17, 6'd1};
    mode_tab[2] = {6'd28, 6'd24, 6'd20, 6'd16};
    vt[0] = mkv(1, 0, 1, 0, 1, 0, 0, 6'd0, 6'd1);
    vt[1] = mkv(1, 1, 1, 0, 1, 1, 0, 6'd0, 6'd1);
    vt[2] = mkv(0, 1, 1, 1, 1, 0, 0, 6'd4, 6'd5);
    vt[3] = mkv(1, 1, 1, 1, 1, 1, 0, 6'd4, 6'd5);
    vt[4] = mkv(1, 0, 1, 1, 1, 0, 0, 6'd8, 6'd9);
    vt[5] = mkv(1, 1, 1, 1, 1, 1, 0, 6'd8, 6'd9);

    rst_n = 1'b0;
    bus.ed = 1'b0;
    bus.in_vld = 1'b0;
    bus.flush = 1'b0;
    for (int l = 0; l < 4; l++) di[l] = '0;

    // Output monitor: one scoreboard pop per newly produced beat (not while ED froze it).
    fork
      forever begin
        @(posedge clk);
        ed_prev = bus.ed;
      end
      forever begin
        @(negedge clk);
        if (rst_n && bus.out_vld && ed_prev) begin
          if (sb.size() == 0) begin
            chk("spurious_out_vld", 80'(bus.out_vld), 80'(0));
          end else begin
            e = sb.pop_front();
            chk("out_beat", 80'({bus.out_first, dout[3], dout[2], dout[1], dout[0]}), 80'(e));
          end
        end
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", 80'({bus.out_vld, bus.out_first, bus.busy, bus.ram_we, bus.ram_ed,
                            bus.in_rdy}), 80'(6'b000101));
    chk("reset_addr", 80'(addrs), 80'({6'd3, 6'd2, 6'd1, 6'd0}));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cycle vectors at the start of the first frame, including one ED-low cycle.
    for (int i = 0; i < 6; i++) begin
      drive(vt[i].vld, 1'b0, vt[i].ed);
      chk("vec", 80'({bus.in_rdy, bus.busy, bus.ram_we, bus.ram_ed, bus.out_vld,
                      bus.ram_addr_0, bus.ram_addr_1}), 80'(vt[i].exp));
      tick();
    end

    // Gapless frames 0..2, then frame 3 with an ED stall (and a lost FLUSH) mid-stream.
    feed(13, 1'b0);
    feed(16, 1'b0);
    feed(16, 1'b0);
    feed(5, 1'b0);
    saved = {addrs, bus.out_vld, bus.out_first};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, k == 2, 1'b0);
      chk("stall_ram_ed", 80'(bus.ram_ed), 80'(0));
      tick();
    end
    chk("stall_hold", 80'({addrs, bus.out_vld, bus.out_first}), 80'(saved));
    feed(11, 1'b0);
    feed(16, 1'b0);

    // Bubbles on IN_VLD for two frames, then a partial frame.
    feed(16, 1'b1);
    feed(16, 1'b1);
    feed(6, 1'b0);

    // Asynchronous reset between edges abandons the buffered data.
    bus.in_vld = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 80'({bus.out_vld, bus.out_first, bus.busy, bus.ram_we}), 80'(4'b0001));
    sb.delete();
    acc_beat = 0;
    frame_no = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frames 0, 1, then FLUSH at beat 7 of frame 2.
    feed(16, 1'b0);
    feed(16, 1'b0);
    feed(7, 1'b0);
    drive(1'b1, 1'b1, 1'b1);
    tick();
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b1, 1'b0, 1'b1);
      if (!bus.in_rdy) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    chk("flush_rdy_drop", 80'({seen, 8'(acc_beat), 8'(frame_no)}), 80'({1'b1, 8'd0, 8'd3}));
    dn = 0;
    for (int k = 0; k < 40; k++) begin
      drive(1'b0, 1'b0, 1'b1);
      if (!bus.busy) break;
      if (!bus.ram_we) dn++;
      tick();
    end
    chk("drain_len", 80'(dn), 80'(16));
    chk("idle_after_drain", 80'({bus.busy, addrs}), 80'({1'b0, 6'd3, 6'd2, 6'd1, 6'd0}));
    frame_no = 0;
    @(negedge clk);
    #1;
    chk("sb_empty", 80'(sb.size()), 80'(0));
    @(posedge clk);
    #1;

    // FLUSH in IDLE is ignored: the next two frames must stream without a drain.
    drive(1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b1);
    chk("idle_flush_ignored", 80'({bus.busy, bus.in_rdy}), 80'(2'b01));
    feed(16, 1'b0);
    feed(4, 1'b0);
    chk("stream_after_idle_flush", 80'({bus.busy, bus.ram_we}), 80'(2'b11));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
